// File: rtl/vector_alu_pipe.sv
// vector_alu_pipe
//   LANES independent WIDTH-bit unsigned ALU lanes sharing one opcode, with
//   valid/ready handshakes on both sides and a two-stage pipeline:
//     stage 1 (p1): per-lane operation result, or the WIDTH+2-bit partial sum
//                   for the interpolation opcodes
//     stage 2 (p2): final lane result (divide-by-3 for interpolation), drives out_data
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   input beat handshake
//     alu_op, vc_sub        opcode and conditional-subtract mode, sampled on accept
//     lane_mask             1 = lane computes, 0 = lane forwards in_a unchanged
//     in_a, in_b            packed operands, lane i at [i*WIDTH +: WIDTH]
//     out_valid / out_ready result handshake
//     out_data              packed result, held while out_valid=0 or stalled
module vector_alu_pipe #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             alu_op,
  input  logic                   vc_sub,
  input  logic [LANES-1:0]       lane_mask,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data
);

  localparam int SW = WIDTH + 2;
  localparam logic [WIDTH-1:0] WLIM  = WIDTH'(WIDTH);
  localparam logic [SW-1:0]    THREE = SW'(3);

  // Per-lane operation. Interpolation opcodes return the undivided sum so the
  // divide can live in the second stage; every other opcode returns its final
  // WIDTH-bit result zero-extended.
  function automatic logic [SW-1:0] lane_op(input logic [2:0] op, input logic vc,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic [SW-1:0]    s;
    r = '0;
    s = '0;
    case (op)
      3'b000: r = a + b;
      3'b001: r = (vc && (a < b)) ? a : a - b;
      3'b010: r = a * b;
      3'b011: r = b;
      3'b100: s = {2'b00, a} + {1'b0, b, 1'b0};
      3'b101: s = {1'b0, a, 1'b0} + {2'b00, b};
      3'b110: r = (b >= WLIM) ? '0 : a << b;
      default: r = (b >= WLIM) ? '0 : a >> b;
    endcase
    if (op[2:1] != 2'b10) s = {2'b00, r};
    return s;
  endfunction

  // Truncating divide by three of an interpolation sum; the quotient of a
  // (WIDTH+2)-bit sum of at most 3*(2^WIDTH-1) always fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] div3(input logic [SW-1:0] x);
    return WIDTH'(x / THREE);
  endfunction

  logic                   vld_p1, vld_p2;
  logic [SW-1:0]          res_p1 [LANES];
  logic [LANES-1:0]       div_p1;
  logic [LANES*WIDTH-1:0] data_p2;

  logic                   adv1, adv2;
  logic [SW-1:0]          res_d  [LANES];
  logic [LANES-1:0]       div_d;
  logic [LANES*WIDTH-1:0] data_d;

  // Stage 2 can take a new beat when empty or being drained this cycle;
  // stage 1 can take one when empty or when it moves into stage 2.
  assign adv2     = !vld_p2 || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      res_d[i] = {2'b00, in_a[i*WIDTH +: WIDTH]};
      div_d[i] = 1'b0;
      if (lane_mask[i]) begin
        res_d[i] = lane_op(alu_op, vc_sub, in_a[i*WIDTH +: WIDTH], in_b[i*WIDTH +: WIDTH]);
        div_d[i] = (alu_op[2:1] == 2'b10);
      end
    end
  end

  always_comb begin
    data_d = '0;
    for (int i = 0; i < LANES; i++) begin
      data_d[i*WIDTH +: WIDTH] = div_p1[i] ? div3(res_p1[i]) : res_p1[i][WIDTH-1:0];
    end
  end

  // Control: stage valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= in_valid;
      if (adv2) vld_p2 <= vld_p1;
    end
  end

  // Stage 1 boundary: operation result / partial sum
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      res_p1 <= res_d;
      div_p1 <= div_d;
    end
  end

  // Stage 2 boundary: final lane result, cleared on reset so out_data reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p2 <= '0;
    end else if (adv2 && vld_p1) begin
      data_p2 <= data_d;
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;

endmodule

// File: tb/tb_vector_alu_pipe.sv
module tb_vector_alu_pipe;
  localparam int W  = 32;
  localparam int L  = 4;
  localparam int LW = W * L;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    alu_op;
  logic          vc_sub;
  logic [L-1:0]  lane_mask;
  logic [LW-1:0] in_a, in_b;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_data;

  vector_alu_pipe #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .vc_sub(vc_sub), .lane_mask(lane_mask),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [LW-1:0] d;
    int            cyc;
    bit            chk;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   sdone  = 0;

  function automatic logic [LW-1:0] pk(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                       input logic [W-1:0] l2, input logic [W-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Present one beat; push its expected result once the accepting edge occurs.
  // chk=1 also requires the result to appear exactly two edges after accept.
  task automatic send(input logic [2:0] op, input logic vc, input logic [L-1:0] m,
                      input logic [LW-1:0] a, input logic [LW-1:0] b,
                      input logic [LW-1:0] e, input bit chk);
    exp_t x;
    int   n;
    bit   got;
    alu_op = op; vc_sub = vc; lane_mask = m; in_a = a; in_b = b; in_valid = 1'b1;
    got = 0;
    n   = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        x.d = e; x.cyc = cyc + 2; x.chk = chk; got = 1;
      end
      @(posedge clk);
      n++;
      if (got) q.push_back(x);
    end
    #1;
    in_valid = 1'b0;
    in_a = ~in_a; in_b = ~in_b; alu_op = ~alu_op; lane_mask = ~lane_mask;
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready never high, op=%b", op);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still outstanding, want 0", q.size());
    end
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL %s: out_valid=%b in_ready=%b out_data=%h, want 0 1 0",
               tag, out_valid, in_ready, out_data);
    end
  endtask

  // Monitor / scoreboard
  logic          prev_stall = 1'b0;
  logic [LW-1:0] prev_d;
  exp_t          mx;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (in_ready !== !(q.size() == 2 && !out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b want %b (occupancy %0d, out_ready %b)",
                 in_ready, !(q.size() == 2 && !out_ready), q.size(), out_ready);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_d) begin
          errors++;
          $display("FAIL stall_hold: out_valid=%b out_data=%h, want 1 %h",
                   out_valid, out_data, prev_d);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h with no beat outstanding", out_data);
        end else begin
          mx = q.pop_front();
          if (out_data !== mx.d) begin
            errors++;
            $display("FAIL data: got %h want %h", out_data, mx.d);
          end
          if (mx.chk) begin
            checks++;
            if (cyc != mx.cyc) begin
              errors++;
              $display("FAIL latency: result at cycle %0d want %0d", cyc, mx.cyc);
            end
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; alu_op = '0; vc_sub = 1'b0;
    lane_mask = '1; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_state");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // multiply
    send(3'b010, 0, 4'hF, pk(1250, 1250, 1250, 1250), pk(342, 342, 342, 342),
         pk(427500, 427500, 427500, 427500), 1);
    // conditional subtract, then plain subtract wrapping
    send(3'b001, 1, 4'hF, pk(1250, 100, 0, 5), pk(342, 342, 0, 6),
         pk(908, 100, 0, 5), 1);
    send(3'b001, 0, 4'hF, pk(1250, 100, 0, 5), pk(342, 342, 0, 6),
         pk(908, 32'hFFFF_FF0E, 0, 32'hFFFF_FFFF), 1);
    // shifts including out-of-range amounts
    send(3'b111, 0, 4'hF, pk(32'h3800_0000, 32'h3800_0000, 32'hFFFF_FFFF, 32'h80),
         pk(23, 32, 100, 4), pk(32'h70, 0, 0, 8), 1);
    send(3'b110, 0, 4'hF, pk(1, 1, 3, 32'hF), pk(31, 32, 1, 0),
         pk(32'h8000_0000, 0, 6, 32'hF), 1);
    // interpolation, including the all-ones extreme
    send(3'b101, 0, 4'hF, pk(10, 32'hFFFF_FFFF, 0, 1), pk(20, 32'hFFFF_FFFF, 0, 1),
         pk(13, 32'hFFFF_FFFF, 0, 1), 1);
    send(3'b100, 0, 4'hF, pk(10, 32'hFFFF_FFFF, 2, 0), pk(20, 32'hFFFF_FFFF, 0, 3),
         pk(16, 32'hFFFF_FFFF, 0, 2), 1);
    // lane mask, add with wrap, pass b, masked interpolation lane
    send(3'b000, 0, 4'b0101, pk(7, 7, 7, 7), pk(3, 3, 3, 3), pk(10, 7, 10, 7), 1);
    send(3'b000, 0, 4'hF, pk(32'hFFFF_FFFF, 2, 0, 9), pk(1, 3, 0, 32'hFFFF_FFF7),
         pk(0, 5, 0, 0), 1);
    send(3'b011, 0, 4'b1110, pk(11, 22, 33, 44), pk(5, 6, 7, 8), pk(11, 6, 7, 8), 1);
    send(3'b100, 0, 4'b0111, pk(10, 10, 10, 99), pk(20, 20, 20, 1), pk(16, 16, 16, 99), 1);
    drain();

    // streaming with out_ready toggling 1010..
    sdone = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [LW-1:0] a, b, e;
          for (int l = 0; l < L; l++) begin
            a[l*W +: W] = W'(i * 16 + l);
            b[l*W +: W] = W'(3 + l);
            e[l*W +: W] = (i % 2 == 1) ? W'((i * 16 + l) * (3 + l)) : W'(i * 16 + l + 3 + l);
          end
          send((i % 2 == 1) ? 3'b010 : 3'b000, 0, 4'hF, a, b, e, 0);
        end
        sdone = 1;
      end
      begin
        while (!sdone) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // reset with the pipe full and stalled
    out_ready = 1'b0;
    send(3'b000, 0, 4'hF, pk(1, 2, 3, 4), pk(1, 1, 1, 1), pk(2, 3, 4, 5), 0);
    send(3'b000, 0, 4'hF, pk(5, 6, 7, 8), pk(1, 1, 1, 1), pk(6, 7, 8, 9), 0);
    rst_n = 1'b0;
    q.delete();
    #1;
    check_reset("mid_reset");
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(3'b010, 0, 4'hF, pk(2, 3, 4, 5), pk(10, 10, 10, 10), pk(20, 30, 40, 50), 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
